// File: rtl/generic_fifo_sync.sv
// generic_fifo_sync: single-clock FIFO with level count,
// almost-full/almost-empty flags and synchronous clear.
module generic_fifo_sync #(
    parameter int dw = 8,
    parameter int aw = 4,
    parameter int n  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [dw-1:0] din,
    input  logic          we,
    output logic [dw-1:0] dout,
    input  logic          re,
    output logic          full,
    output logic          empty,
    output logic          full_n,
    output logic          empty_n,
    output logic [aw:0]   level
);

    localparam int DEPTH = 1 << aw;

    localparam logic [aw:0]   LV_FULL = (aw+1)'(DEPTH);
    localparam logic [aw:0]   LV_AF   = (aw+1)'(DEPTH - n);
    localparam logic [aw:0]   LV_AE   = (aw+1)'(n);
    localparam logic [aw:0]   LV_ONE  = (aw+1)'(1);
    localparam logic [aw-1:0] PT_ONE  = aw'(1);

    logic [dw-1:0] mem [DEPTH];
    logic [aw-1:0] wp;
    logic [aw-1:0] rp;
    logic [aw:0]   cnt;
    logic          wa;
    logic          ra;

    assign wa = we && !full && !clr;
    assign ra = re && !empty && !clr;

    assign level   = cnt;
    assign empty   = (cnt == '0);
    assign full    = (cnt == LV_FULL);
    assign full_n  = (cnt >= LV_AF);
    assign empty_n = (cnt <= LV_AE);

    // Storage has no reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (wa)
            mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wa)
                wp <= wp + PT_ONE;
            if (ra)
                rp <= rp + PT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            unique case ({wa, ra})
                2'b10:   cnt <= cnt + LV_ONE;
                2'b01:   cnt <= cnt - LV_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // dout holds through clear and ignored reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dout <= '0;
        else if (ra)
            dout <= mem[rp];
    end

endmodule

// File: tb/tb_generic_fifo_sync.sv
// tb_generic_fifo_sync: random and directed stimulus checked
// against a queue-based model of the FIFO.
module tb_generic_fifo_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] din = '0;
    logic       we  = 1'b0;
    logic       re  = 1'b0;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       full_n;
    logic       empty_n;
    logic [4:0] level;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [7:0] q[$];
    logic [7:0] dout_m = 8'h00;

    generic_fifo_sync #(.dw(8), .aw(4), .n(2)) dut (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we),
        .dout(dout), .re(re), .full(full), .empty(empty),
        .full_n(full_n), .empty_n(empty_n), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Model: a plain queue; flags from its size.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout", int'(dout), int'(dout_m));
            chk("level", int'(level), q.size());
            chk("full", int'(full), int'(q.size() == 16));
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("full_n", int'(full_n), int'(q.size() >= 14));
            chk("empty_n", int'(empty_n), int'(q.size() <= 2));
        end
    end

    task automatic drive(input logic w, input logic r,
                         input logic c, input logic [7:0] d);
        int sz;
        we  = w;
        re  = r;
        clr = c;
        din = d;
        @(posedge clk);
        sz = q.size();
        if (c) begin
            q.delete();
        end else begin
            if (r && sz != 0)
                dout_m = q.pop_front();
            if (w && sz != 16)
                q.push_back(d);
        end
        #1;
        we  = 1'b0;
        re  = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_empty_n", int'(empty_n), 1);
        chk("rst_full_n", int'(full_n), 0);
        rst = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(i));
            if (i == 12) chk("full_n_13", int'(full_n), 0);
            if (i == 13) chk("full_n_14", int'(full_n), 1);
        end
        chk("fill_full", int'(full), 1);
        chk("fill_level", int'(level), 16);
        drive(1'b1, 1'b0, 1'b0, 8'hAA);
        chk("ovf_level", int'(level), 16);

        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            chk("drain_dout", int'(dout), i);
        end
        chk("drain_empty", int'(empty), 1);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        chk("udf_dout", int'(dout), 8'h0F);

        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        drive(1'b1, 1'b1, 1'b0, 8'h99);
        chk("rw_level5", int'(level), 5);
        chk("rw_dout", int'(dout), 8'h40);

        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 99) == 0),
                  8'($urandom_range(0, 255)));

        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++)
            drive(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h36);
        chk("pre_clr_level", int'(level), 6);
        drive(1'b1, 1'b1, 1'b1, 8'h77);
        chk("clr_level", int'(level), 0);
        chk("clr_empty", int'(empty), 1);
        chk("clr_dout", int'(dout), 8'h30);

        for (int i = 0; i < 9; i++)
            drive(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        chk("pre_rst_level", int'(level), 9);
        #1 rst = 1'b0;
        q.delete();
        dout_m = 8'h00;
        #1;
        chk("arst_empty", int'(empty), 1);
        chk("arst_level", int'(level), 0);
        chk("arst_dout", int'(dout), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h5C);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        chk("post_rst_dout", int'(dout), 8'h5C);
        chk("post_rst_empty", int'(empty), 1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
